key_operand_loader: RTL and testbench
=====================================

// Module: key_operand_loader
// PURPOSE
//  Consumes key codes from the teclado_matricial scanner and assembles two signed
//  decimal operands (A, then B) for the Booth multiplier core.
//  Digits accumulate as binary (acc*10+d). Sign, clear and enter keys edit the entry.
//  When both operands are confirmed it presents them on a valid/ready handshake.
// PARAMETERS
//  OP_WIDTH  8  operand width, two's complement; magnitude limit MAXMAG = 2^(OP_WIDTH-1)-1
//  N_DIGITS  3  max decimal digits accepted per operand (leading zeros count)
// PORTS
//  clk         in   1         system clock (27 MHz)
//  rst         in   1         asynchronous reset, active-low
//  key_code    in   4         key code from scanner (key_out)
//  key_valid   in   1         1-cycle strobe: key_code valid, one strobe per press
//  op_ready    in   1         multiplier accepts operands
//  op_valid    out  1         op_a/op_b valid and stable
//  op_a        out  OP_WIDTH  operand A, signed
//  op_b        out  OP_WIDTH  operand B, signed
//  entry_sel   out  1         0 = editing A, 1 = editing B (display)
//  disp_mag    out  OP_WIDTH  magnitude of the operand being edited (display)
//  disp_neg    out  1         sign flag of the operand being edited
//  digit_cnt   out  2         digits entered so far in current operand
//  key_err     out  1         1-cycle pulse: key rejected
// BEHAVIOUR
//  Reset (rst=0, async): state ENTER_A; every output 0; internal mag, neg and count 0.
//  Key map: 0x0-0x9 digit, 0xA ENTER, 0xB CLEAR, 0xC SIGN, 0xD-0xF ignored (no err).
//  Keys are sampled only when key_valid=1. All effects appear registered on the next cycle.
//  Digit d: if digit_cnt==N_DIGITS or mag*10+d > MAXMAG, reject (key_err, no change).
//   Otherwise mag <= mag*10+d, digit_cnt+1. Compute mag*10+d at OP_WIDTH+4 bits.
//  SIGN: toggles neg, with or without digits; no count change.
//  CLEAR: mag=0, neg=0, cnt=0 for the current operand. State is unchanged in ENTER_A/B.
//  ENTER with digit_cnt==0: reject (key_err).
//   Otherwise latch the operand as neg ? -mag : mag and clear the edit regs.
//  FSM:
//   ENTER_A --ENTER ok--> ENTER_B: op_a latched, entry_sel=1.
//   ENTER_B --ENTER ok--> WAIT_MULT: op_b latched, op_valid=1 in the same update.
//   WAIT_MULT: op_valid=1, op_a/op_b held. Digit, SIGN and ENTER ignored, no err.
//    op_valid & op_ready --> ENTER_A: op_valid=0, entry_sel=0.
//     op_a/op_b keep their values until overwritten.
//    CLEAR (without op_ready) --> ENTER_A: aborts, op_valid=0, op_a/op_b=0.
//   Priority: handshake over a simultaneous CLEAR; that key is dropped.
//  op_valid never drops without a handshake, except on CLEAR or reset.
//  -0 latches as 0. key_err stays 0 when key_valid=0.
// TESTING
//  T1: reset low for 3 cycles -> all outputs 0, entry_sel=0.
//  T2: keys 1,2,ENTER,SIGN,5,ENTER -> op_a=12, op_b=-5 (0xFB), op_valid=1.
//   op_ready=1 -> op_valid=0 the next cycle, entry_sel=0.
//  T3: keys 1,2,8 -> third digit rejected (key_err pulse), disp_mag=12.
//   Then 0,0,1,2 -> the 4th digit is rejected.
//  T4: ENTER with no digits -> key_err, state stays ENTER_A.
//   Keys 7,CLEAR,3,ENTER -> op_a=3.
//  T5: in WAIT_MULT, send 9 and SIGN -> no change, no err.
//   CLEAR -> op_valid=0, op_a=op_b=0.
//   Repeat, with CLEAR and op_ready in the same cycle -> transfer completes, ops held.
//  T6: assert rst mid-entry of B (mag=4) -> immediate async clear, ENTER_A after release.

Source files
------------

// File: rtl/key_operand_loader.sv
// Assembles two signed decimal operands from scanner key codes and offers them
// to the multiplier on a valid/ready handshake.
module key_operand_loader #(
  parameter int OP_WIDTH = 8,
  parameter int N_DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          key_code,
  input  logic                key_valid,
  input  logic                op_ready,
  output logic                op_valid,
  output logic [OP_WIDTH-1:0] op_a,
  output logic [OP_WIDTH-1:0] op_b,
  output logic                entry_sel,
  output logic [OP_WIDTH-1:0] disp_mag,
  output logic                disp_neg,
  output logic [1:0]          digit_cnt,
  output logic                key_err
);

  localparam int XW = OP_WIDTH + 4;
  localparam logic [XW-1:0] MAXMAG = XW'((1 << (OP_WIDTH - 1)) - 1);
  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_SIGN  = 4'hC;

  typedef enum logic [1:0] {ENTER_A, ENTER_B, WAIT_MULT} state_t;

  state_t                state, state_n;
  logic [OP_WIDTH-1:0]   mag, mag_n;
  logic                  neg, neg_n;
  logic [1:0]            cnt, cnt_n;
  logic [OP_WIDTH-1:0]   op_a_q, op_a_n;
  logic [OP_WIDTH-1:0]   op_b_q, op_b_n;
  logic                  err_q, err_n;

  logic [XW-1:0]         cand;
  logic [OP_WIDTH-1:0]   entry_val;
  logic                  digit_ok;

  // Candidate is formed wide so the overflow test cannot wrap.
  assign cand      = {4'b0000, mag} * XW'(10) + XW'(key_code);
  assign digit_ok  = (cnt != 2'(N_DIGITS)) && (cand <= MAXMAG);
  assign entry_val = neg ? (OP_WIDTH'(0) - mag) : mag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ENTER_A;
      mag    <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      mag    <= mag_n;
      neg    <= neg_n;
      cnt    <= cnt_n;
      op_a_q <= op_a_n;
      op_b_q <= op_b_n;
      err_q  <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    mag_n   = mag;
    neg_n   = neg;
    cnt_n   = cnt;
    op_a_n  = op_a_q;
    op_b_n  = op_b_q;
    err_n   = 1'b0;
    case (state)
      WAIT_MULT: begin
        // A completed handshake wins over a CLEAR arriving in the same cycle.
        if (op_ready) begin
          state_n = ENTER_A;
        end else if (key_valid && key_code == KEY_CLEAR) begin
          state_n = ENTER_A;
          op_a_n  = '0;
          op_b_n  = '0;
          mag_n   = '0;
          neg_n   = 1'b0;
          cnt_n   = '0;
        end
      end
      default: begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (digit_ok) begin
              mag_n = cand[OP_WIDTH-1:0];
              cnt_n = cnt + 2'd1;
            end else begin
              err_n = 1'b1;
            end
          end else if (key_code == KEY_ENTER) begin
            if (cnt == 2'd0) begin
              err_n = 1'b1;
            end else begin
              if (state == ENTER_A) begin
                op_a_n  = entry_val;
                state_n = ENTER_B;
              end else begin
                op_b_n  = entry_val;
                state_n = WAIT_MULT;
              end
              mag_n = '0;
              neg_n = 1'b0;
              cnt_n = '0;
            end
          end else if (key_code == KEY_CLEAR) begin
            mag_n = '0;
            neg_n = 1'b0;
            cnt_n = '0;
          end else if (key_code == KEY_SIGN) begin
            neg_n = ~neg;
          end
        end
      end
    endcase
  end

  assign op_valid  = (state == WAIT_MULT);
  assign entry_sel = (state != ENTER_A);
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign disp_mag  = mag;
  assign disp_neg  = neg;
  assign digit_cnt = cnt;
  assign key_err   = err_q;

endmodule

// File: tb/tb_key_operand_loader.sv
// Directed bench for key_operand_loader: a behavioural operand-entry model is
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_key_operand_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_code;
  logic       key_valid;
  logic       op_ready;
  logic       op_valid;
  logic [7:0] op_a, op_b, disp_mag;
  logic       entry_sel, disp_neg, key_err;
  logic [1:0] digit_cnt;

  int vectors = 0;
  int miscompares = 0;

  key_operand_loader #(.OP_WIDTH(8), .N_DIGITS(3)) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
    .op_ready(op_ready), .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
    .entry_sel(entry_sel), .disp_mag(disp_mag), .disp_neg(disp_neg),
    .digit_cnt(digit_cnt), .key_err(key_err)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = editing A, 1 = editing B, 2 = operands offered.
  int m_phase, m_mag, m_cnt, m_opa, m_opb, m_val, k;
  bit m_neg, m_err;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_mag = 0; m_cnt = 0; m_opa = 0; m_opb = 0;
      m_neg = 0; m_err = 0;
    end else begin
      m_err = 0;
      k = int'(key_code);
      if (m_phase == 2) begin
        if (op_ready) m_phase = 0;
        else if (key_valid && k == 11) begin
          m_phase = 0; m_opa = 0; m_opb = 0;
        end
      end else if (key_valid) begin
        if (k <= 9) begin
          if (m_cnt == 3 || m_mag * 10 + k > 127) m_err = 1;
          else begin m_mag = m_mag * 10 + k; m_cnt = m_cnt + 1; end
        end else if (k == 10) begin
          if (m_cnt == 0) m_err = 1;
          else begin
            m_val = m_neg ? -m_mag : m_mag;
            if (m_phase == 0) begin m_opa = m_val; m_phase = 1; end
            else begin m_opb = m_val; m_phase = 2; end
            m_mag = 0; m_neg = 0; m_cnt = 0;
          end
        end else if (k == 11) begin
          m_mag = 0; m_neg = 0; m_cnt = 0;
        end else if (k == 12) begin
          m_neg = !m_neg;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("op_valid",  int'(op_valid),  int'(m_phase == 2));
    check("entry_sel", int'(entry_sel), int'(m_phase != 0));
    check("op_a",      int'(op_a),      int'(m_opa[7:0]));
    check("op_b",      int'(op_b),      int'(m_opb[7:0]));
    check("disp_mag",  int'(disp_mag),  m_mag);
    check("disp_neg",  int'(disp_neg),  int'(m_neg));
    check("digit_cnt", int'(digit_cnt), m_cnt);
    check("key_err",   int'(key_err),   int'(m_err));
  end

  // Called at a negedge; returns at the next negedge with the key's effect visible.
  task automatic press(input logic [3:0] kc);
    key_code  = kc;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; key_code = '0; key_valid = 1'b0; op_ready = 1'b0;
    // T1: reset state
    repeat (3) @(negedge clk);
    check("t1_op_valid", int'(op_valid), 0);
    check("t1_entry_sel", int'(entry_sel), 0);
    check("t1_op_a", int'(op_a), 0);
    check("t1_key_err", int'(key_err), 0);
    rst = 1'b1;
    @(negedge clk);

    // T2: 12 ENTER, SIGN 5 ENTER, handshake
    press(4'h1); press(4'h2); press(4'hA);
    check("t2_op_a_mid", int'(op_a), 12);
    check("t2_entry_b", int'(entry_sel), 1);
    press(4'hC); press(4'h5); press(4'hA);
    check("t2_op_a", int'(op_a), 12);
    check("t2_op_b", int'(op_b), 'hFB);
    check("t2_model_op_b", int'(m_opb[7:0]), 'hFB);
    check("t2_op_valid", int'(op_valid), 1);
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    check("t2_valid_drop", int'(op_valid), 0);
    check("t2_entry_a", int'(entry_sel), 0);
    check("t2_op_a_held", int'(op_a), 12);

    // T3: magnitude and digit-count limits
    press(4'h1); press(4'h2); press(4'h8);
    check("t3_err_mag", int'(key_err), 1);
    check("t3_disp_mag", int'(disp_mag), 12);
    check("t3_model_mag", m_mag, 12);
    press(4'hB);
    press(4'h0); press(4'h0); press(4'h1);
    check("t3_cnt3", int'(digit_cnt), 3);
    press(4'h2);
    check("t3_err_cnt", int'(key_err), 1);
    check("t3_disp_mag2", int'(disp_mag), 1);
    press(4'hB);

    // T4: empty ENTER, clear mid-entry
    press(4'hA);
    check("t4_err_enter", int'(key_err), 1);
    check("t4_still_a", int'(entry_sel), 0);
    press(4'h7); press(4'hB); press(4'h3); press(4'hA);
    check("t4_op_a", int'(op_a), 3);
    press(4'h4); press(4'hA);

    // T5: WAIT_MULT ignores keys; CLEAR aborts; handshake beats CLEAR
    press(4'h9); press(4'hC);
    check("t5_no_err", int'(key_err), 0);
    check("t5_held_b", int'(op_b), 4);
    check("t5_valid", int'(op_valid), 1);
    press(4'hB);
    check("t5_abort_valid", int'(op_valid), 0);
    check("t5_abort_a", int'(op_a), 0);
    check("t5_abort_b", int'(op_b), 0);
    press(4'h2); press(4'hA); press(4'h6); press(4'hA);
    key_code = 4'hB; key_valid = 1'b1; op_ready = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; op_ready = 1'b0;
    check("t5_hs_valid", int'(op_valid), 0);
    check("t5_hs_a", int'(op_a), 2);
    check("t5_hs_b", int'(op_b), 6);
    check("t5_hs_err", int'(key_err), 0);

    // T6: async reset while editing B
    press(4'h1); press(4'hA); press(4'h4);
    check("t6_mag4", int'(disp_mag), 4);
    #2 rst = 1'b0;
    #1;
    check("t6_async_mag", int'(disp_mag), 0);
    check("t6_async_a", int'(op_a), 0);
    check("t6_async_sel", int'(entry_sel), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    press(4'hD);
    check("t6_ignored", int'(key_err), 0);
    press(4'hC); press(4'h0); press(4'hA);
    check("t6_neg_zero", int'(op_a), 0);
    check("t6_entry_b", int'(entry_sel), 1);
    press(4'h5); press(4'hA);
    check("t6_op_b", int'(op_b), 5);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
